// File: rtl/alu_pkg.sv
// Shared opcode/state definitions for the sequential accumulator ALU.
package alu_pkg;

    localparam int OPW           = 4;
    localparam int OP_LAST_LEGAL = 9;

    typedef enum logic [OPW-1:0] {
        OP_PASS = 4'd0,
        OP_NOT  = 4'd1,
        OP_NEG  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU datapath: result, signed overflow and illegal-op.
// ALU_SAT_EN: when defined, ADD/SUB/NEG saturate on overflow instead of wrapping.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 11
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             ovf,
    output logic             ill
);

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] neg_s;
    logic [WIDTH-1:0] sat_s;

    assign sum_s  = acc + b;
    assign diff_s = acc - b;
    assign neg_s  = ~acc + ONE_V;
    // An ADD/SUB overflow always has the true result sign equal to acc's sign.
    assign sat_s  = acc[WIDTH-1] ? MIN_V : MAX_V;

    // Opcode decode and result select
    always_comb begin
        res = {WIDTH{1'b0}};
        ovf = 1'b0;
        ill = 1'b0;
        case (op)
            OP_PASS: res = acc;
            OP_NOT:  res = ~acc;
            OP_NEG: begin
                ovf = (acc == MIN_V);
                res = (SAT && ovf) ? MAX_V : neg_s;
            end
            OP_ADD: begin
                ovf = (acc[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != acc[WIDTH-1]);
                res = (SAT && ovf) ? sat_s : sum_s;
            end
            OP_SUB: begin
                ovf = (acc[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != acc[WIDTH-1]);
                res = (SAT && ovf) ? sat_s : diff_s;
            end
            OP_AND:  res = acc & b;
            OP_OR:   res = acc | b;
            OP_XOR:  res = acc ^ b;
            // Zero-amount shifts resolve here; nonzero amounts go through the sequencer.
            OP_SHL:  res = acc;
            OP_SHR:  res = acc;
            default: begin
                res = {WIDTH{1'b0}};
                ill = (op > OP_LAST_LEGAL[OPW-1:0]);
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential accumulator ALU: valid/ready handshake, bit-serial shifter, registered flags.
// ALU_SAT_EN (see alu_core) selects saturating ADD/SUB/NEG.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_ill
);

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH);

    alu_state_t       state_r;
    logic [WIDTH-1:0] work_r;
    logic [SHW-1:0]   cnt_r;
    logic             shr_r;

    logic [WIDTH-1:0] core_res_s;
    logic             core_ovf_s;
    logic             core_ill_s;
    logic [SHW-1:0]   shamt_s;
    logic [SHW-1:0]   shamt_clamp_s;
    logic             is_shift_s;
    logic             accept_s;
    logic [WIDTH-1:0] work_next_s;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op  (op),
        .acc (acc),
        .b   (b),
        .res (core_res_s),
        .ovf (core_ovf_s),
        .ill (core_ill_s)
    );

    assign shamt_s       = b[SHW-1:0];
    assign shamt_clamp_s = (shamt_s > CNT_MAX) ? CNT_MAX : shamt_s;
    assign is_shift_s    = (op == OP_SHL) || (op == OP_SHR);
    assign in_ready      = (state_r == IDLE) || ((state_r == HOLD) && out_ready);
    assign accept_s      = in_valid && in_ready;
    assign work_next_s   = shr_r ? {work_r[WIDTH-1], work_r[WIDTH-1:1]}
                                 : {work_r[WIDTH-2:0], 1'b0};

    // Control FSM, serial shifter and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            work_r    <= {WIDTH{1'b0}};
            cnt_r     <= {SHW{1'b0}};
            shr_r     <= 1'b0;
            out_valid <= 1'b0;
            out       <= {WIDTH{1'b0}};
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            flag_ill  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, HOLD: begin
                    if (accept_s) begin
                        if (is_shift_s && (shamt_s != {SHW{1'b0}})) begin
                            work_r    <= acc;
                            cnt_r     <= shamt_clamp_s;
                            shr_r     <= (op == OP_SHR);
                            out_valid <= 1'b0;
                            state_r   <= SHIFT;
                        end else begin
                            out       <= core_res_s;
                            flag_z    <= (core_res_s == {WIDTH{1'b0}});
                            flag_n    <= core_res_s[WIDTH-1];
                            flag_v    <= core_ovf_s;
                            flag_ill  <= core_ill_s;
                            out_valid <= 1'b1;
                            state_r   <= HOLD;
                        end
                    end else if ((state_r == HOLD) && out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= state_r;
                    end
                end
                SHIFT: begin
                    work_r <= work_next_s;
                    cnt_r  <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        out       <= work_next_s;
                        flag_z    <= (work_next_s == {WIDTH{1'b0}});
                        flag_n    <= work_next_s[WIDTH-1];
                        flag_v    <= 1'b0;
                        flag_ill  <= 1'b0;
                        out_valid <= 1'b1;
                        state_r   <= HOLD;
                    end else begin
                        state_r   <= SHIFT;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=11): directed table, random vs. reference model, corner sequences.
module tb_alu_seq;

    localparam int W   = 11;
    localparam int MAXI = 1023;
    localparam int MINI = -1024;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] acc = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, flag_z, flag_n, flag_v, flag_ill;
    logic [W-1:0] out;

    int total = 0;
    int passed = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc(acc), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .flag_ill(flag_ill)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic [3:0]   fl;   // {z, n, v, ill}
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] out;
        logic [3:0]   fl;
        int           lat;
    } res_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_z, flag_n, flag_v, flag_ill};
    endfunction

    function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] bb,
                                input logic [W-1:0] r, input logic [3:0] f, input int l);
        vec_t v;
        v.op = o; v.a = a; v.b = bb; v.out = r; v.fl = f; v.lat = l;
        return v;
    endfunction

    // Reference model: integer arithmetic on the signed operand values.
    function automatic res_t model(input logic [3:0] m_op, input logic [W-1:0] a, input logic [W-1:0] bb);
        res_t r;
        int sa, sb, t, k;
        bit v;
        bit ill;
        logic [31:0] tv;
        sa = $signed(a);
        sb = $signed(bb);
        k = int'(bb[4:0]);
        if (k > W) k = W;
        v = 1'b0;
        ill = 1'b0;
        case (m_op)
            4'd0: t = sa;
            4'd1: t = -sa - 1;
            4'd2: begin t = -sa; v = (t > MAXI); end
            4'd3: begin t = sa + sb; v = (t > MAXI) || (t < MINI); end
            4'd4: begin t = sa - sb; v = (t > MAXI) || (t < MINI); end
            4'd5: t = $signed(a & bb);
            4'd6: t = $signed(a | bb);
            4'd7: t = $signed(a ^ bb);
            4'd8: t = sa * (1 << k);
            4'd9: t = sa >>> k;
            default: begin t = 0; ill = 1'b1; end
        endcase
`ifdef ALU_SAT_EN
        if (v) t = (t > MAXI) ? MAXI : MINI;
`endif
        tv = t;
        r.out = tv[W-1:0];
        r.fl = {(r.out == '0), r.out[W-1], v, ill};
        r.lat = ((m_op == 4'd8 || m_op == 4'd9) && k > 0) ? k + 1 : 1;
        return r;
    endfunction

    // One transaction: accept, wait for result, optionally hold off out_ready, then release.
    task automatic txn(input logic [3:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                       input int hold, output logic [W-1:0] o, output logic [3:0] fl,
                       output int lat, output bit bad_ready, output bit unstable);
        int guard;
        guard = 0;
        bad_ready = 1'b0;
        unstable = 1'b0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        op = t_op; acc = t_a; b = t_b; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            if (in_ready) bad_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        o = out;
        fl = flags_now();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || out !== o || flags_now() !== fl) unstable = 1'b1;
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    vec_t vecs[16];

    initial begin
        logic [W-1:0] o, ra, rb, hold_out;
        logic [3:0]   fl, ro, hold_fl;
        int           lat;
        bit           br, us, bad;
        res_t         exp_r;

        vecs[0]  = mk(4'd1, 11'd3,     11'd0,     11'h7FC, 4'b0100, 1);
        vecs[1]  = mk(4'd1, 11'h419,   11'd0,     11'd998, 4'b0000, 1);
`ifdef ALU_SAT_EN
        vecs[2]  = mk(4'd3, 11'd999,   11'd999,   11'd1023, 4'b0010, 1);
        vecs[3]  = mk(4'd2, 11'h400,   11'd0,     11'd1023, 4'b0010, 1);
        vecs[9]  = mk(4'd4, 11'h400,   11'd1,     11'h400,  4'b0110, 1);
`else
        vecs[2]  = mk(4'd3, 11'd999,   11'd999,   11'h7CE,  4'b0110, 1);
        vecs[3]  = mk(4'd2, 11'h400,   11'd0,     11'h400,  4'b0110, 1);
        vecs[9]  = mk(4'd4, 11'h400,   11'd1,     11'd1023, 4'b0010, 1);
`endif
        vecs[4]  = mk(4'd9, 11'h7F7,   11'd2,     11'h7FD, 4'b0100, 3);
        vecs[5]  = mk(4'd8, 11'd5,     11'd15,    11'd0,   4'b1000, 12);
        vecs[6]  = mk(4'd12, 11'd77,   11'd5,     11'd0,   4'b1001, 1);
        vecs[7]  = mk(4'd0, 11'd7,     11'd3,     11'd7,   4'b0000, 1);
        vecs[8]  = mk(4'd4, 11'd5,     11'd7,     11'h7FE, 4'b0100, 1);
        vecs[10] = mk(4'd5, 11'h0F0,   11'h0FF,   11'h0F0, 4'b0000, 1);
        vecs[11] = mk(4'd7, 11'h5A5,   11'h5A5,   11'd0,   4'b1000, 1);
        vecs[12] = mk(4'd9, 11'h7FB,   11'd0,     11'h7FB, 4'b0100, 1);
        vecs[13] = mk(4'd9, 11'h400,   11'd20,    11'h7FF, 4'b0100, 12);
        vecs[14] = mk(4'd6, 11'h400,   11'h001,   11'h401, 4'b0100, 1);
        vecs[15] = mk(4'd8, 11'd1,     11'd10,    11'h400, 4'b0100, 11);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_flags", 32'(flags_now()), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            txn(vecs[i].op, vecs[i].a, vecs[i].b, 0, o, fl, lat, br, us);
            chk($sformatf("vec%0d_out", i), 32'(o), 32'(vecs[i].out));
            chk($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_ready_low_in_shift", i), 32'(br), 32'd0);
        end

        // Randomized transactions against the model, with random backpressure
        for (int n = 0; n < 150; n++) begin
            ro = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = (ro == 4'd8 || ro == 4'd9) ? W'($urandom_range(0, 31)) : W'($urandom);
            exp_r = model(ro, ra, rb);
            txn(ro, ra, rb, $urandom_range(0, 3), o, fl, lat, br, us);
            chk($sformatf("rnd%0d_out op=%0d", n, ro), 32'(o), 32'(exp_r.out));
            chk($sformatf("rnd%0d_flags op=%0d", n, ro), 32'(fl), 32'(exp_r.fl));
            chk($sformatf("rnd%0d_latency op=%0d", n, ro), 32'(lat), 32'(exp_r.lat));
            chk($sformatf("rnd%0d_hold_stable", n), 32'(us), 32'd0);
            chk($sformatf("rnd%0d_ready_low_in_shift", n), 32'(br), 32'd0);
        end

        // Backpressure then back-to-back accept on the release cycle
        op = 4'd3; acc = 11'd100; b = 11'd23; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_out", 32'(out), 32'd123);
        hold_out = out;
        hold_fl = flags_now();
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || in_ready || out !== hold_out || flags_now() !== hold_fl) bad = 1'b1;
        end
        chk("bp_stable_5_cycles", 32'(bad), 32'd0);
        op = 4'd12; acc = 11'd55; b = 11'd9; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_illegal_out", 32'(out), 32'd0);
        chk("b2b_illegal_flags", 32'(flags_now()), 32'b1001);
        @(negedge clk);

        // Full-throughput single-cycle stream
        for (int n = 0; n < 4; n++) begin
            ro = (n % 2 == 0) ? 4'd3 : 4'd4;
            ra = W'($urandom);
            rb = W'($urandom);
            exp_r = model(ro, ra, rb);
            op = ro; acc = ra; b = rb; in_valid = 1'b1;
            #1;
            chk($sformatf("stream%0d_in_ready", n), 32'(in_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stream%0d_out", n), 32'({out_valid, out}), 32'({1'b1, exp_r.out}));
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a shift
        txn(4'd0, 11'd55, 11'd0, 0, o, fl, lat, br, us);
        chk("pre_reset_pass", 32'(o), 32'd55);
        op = 4'd8; acc = 11'd100; b = 11'd8; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midshift_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midshift_reset_valid", 32'(out_valid), 32'd0);
        chk("midshift_reset_out", 32'(out), 32'd0);
        chk("midshift_reset_flags", 32'(flags_now()), 32'd0);
        chk("midshift_reset_in_ready", 32'(in_ready), 32'd1);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("midshift_result_discarded", 32'(bad), 32'd0);
        txn(4'd0, 11'd7, 11'd0, 0, o, fl, lat, br, us);
        chk("post_reset_pass_out", 32'(o), 32'd7);
        chk("post_reset_pass_latency", 32'(lat), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential accumulator ALU for the SincereMicro datapath; successor to the combinational single-op units (`notop` and its siblings). It accepts one operation per transaction over a valid/ready handshake and supports NOT, NEG, ADD, SUB, AND, OR, XOR, PASS and multi-cycle arithmetic/logical shifts. Each result is registered together with zero/negative/overflow/illegal flags. It sits between the decode stage and accumulator writeback.

## Interface
- `WIDTH`, 11: operand/result width, two's-complement signed, must be ≥ 2.
- `SHW`, `$clog2(WIDTH)+1`: shift-amount width, taken from `b[SHW-1:0]`.
- `clk` in 1: sole clock; all state changes on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operation request valid.
- `in_ready` out 1: block can accept a request this cycle.
- `op` in 4: opcode. 0 PASS, 1 NOT, 2 NEG, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR (arithmetic). 10–15 are illegal.
- `acc` in WIDTH: operand A (accumulator).
- `b` in WIDTH: operand B; the low SHW bits give the shift amount for ops 8/9.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out` out WIDTH: result.
- `flag_z`, `flag_n`, `flag_v`, `flag_ill` out 1 each: zero, negative (`out[WIDTH-1]`), signed overflow, illegal opcode.

## Operation
- FSM states: IDLE, SHIFT, HOLD.
- **IDLE, accept** (`in_valid && in_ready`):
  - Single-cycle op: result and flags are registered; go to HOLD.
  - Shift with shamt 0: same as a single-cycle op.
  - Shift with shamt > 0: latch operand and count; go to SHIFT.
- **SHIFT**:
  - Shifts the working register by one bit per cycle and decrements the count.
  - When the count reaches 0, registers the result and goes to HOLD.
  - shamt ≥ WIDTH is clamped to WIDTH. SHL then yields 0; SHR yields all sign bits.
- **HOLD**:
  - `out_valid`=1; `out` and flags stay stable until `out_ready`.
  - On `out_ready`, go to IDLE. If `in_valid` is asserted in the same cycle, accept the new request instead.
- `in_ready` = (state==IDLE) || (state==HOLD && out_ready). It is low in SHIFT.
- Arithmetic is WIDTH-bit, wrapping modulo 2^WIDTH.
- `flag_v`:
  - ADD: operands have equal signs and the result sign differs.
  - SUB: operands have different signs and the result sign differs from acc.
  - NEG: acc = −2^(WIDTH−1).
  - All other ops: 0.
- Illegal opcode: `out`=0, `flag_ill`=1, `flag_z`=1, single-cycle.
- `flag_z` = (out==0). `flag_n` = out MSB. Both are computed from the final registered result.

## Timing
- Reset, checked at a rising edge with `rst_n`=0: state=IDLE, `out_valid`=0, `out`=0, all flags 0, `in_ready`=1 from the next cycle.
- Reset takes priority over everything, including mid-SHIFT and HOLD; any in-flight result is discarded.
- Latency, measured as accept edge to `out_valid` high:
  - Single-cycle ops and shamt 0: 1 cycle.
  - Shift: min(shamt, WIDTH)+1 cycles.
- Throughput is one transaction per cycle for single-cycle ops while `out_ready` stays 1.
- `out_valid` never drops without an `out_ready` handshake. `out` and flags never change while `out_valid && !out_ready`.

## Configuration
- `ALU_SAT_EN` defined: ADD, SUB and NEG saturate on overflow to 2^(WIDTH−1)−1 or −2^(WIDTH−1), chosen by the sign of the true result. `flag_v` is still set.
- `ALU_SAT_EN` undefined: results wrap. `flag_v` behaviour is identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - The opcode enum `alu_op_t` (4 bits, values as listed above).
  - The state enum `alu_state_t`.
  - The constants `OP_LAST_LEGAL`=9 and `OPW`=4.
- Sub-module `alu_core` is purely combinational. It takes `op`, `acc`, `b` and produces the single-cycle result and overflow. `alu_seq` instantiates one and owns the FSM, shifter, handshake and flag registers.

## Test plan
All scenarios use WIDTH=11.
- **NOT:** acc=3, op=1 → `out`=−4, `flag_n`=1, `out_valid` one cycle after accept. Also acc=−999 → `out`=998.
- **ADD overflow:** acc=999, b=999, op=3 → `out`=−50, `flag_v`=1 (wrap build). Under `ALU_SAT_EN` → `out`=1023, `flag_v`=1.
- **NEG of minimum:** acc=−1024, op=2 → `out`=−1024, `flag_v`=1. Under `ALU_SAT_EN` → `out`=1023.
- **Shifts:**
  - acc=−9, b=2, op=9 → `out`=−3, `out_valid` 3 cycles after accept, `in_ready`=0 during SHIFT.
  - acc=5, b=15, op=8 → `out`=0, `flag_z`=1, latency 12.
- **Backpressure:** ADD result with `out_ready`=0 for 5 cycles → `out` and flags stable, `in_ready`=0. Then assert `out_ready` and `in_valid` together → back-to-back accept, next result 1 cycle later. Illegal op=12 → `flag_ill`=1, `out`=0.
- **Reset mid-shift:** `rst_n`=0 for one edge during SHIFT of acc=100, b=8 → `out_valid`=0, `out`=0, all flags 0, state IDLE. A new PASS of 7 afterwards → `out`=7.
